// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_resp_pkg;

  // Responder control states: waiting, counting down an access, presenting the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Byte address bits below the word index.
  localparam int WORD_OFFSET = 2;

  // Value driven on the read-data path whenever no load is being returned (stores included).
  localparam int STORE_RDATA = 0;

  // Latency counter width; a one-cycle latency still needs a single bit.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Synchronous single-port word array backing the responder.
// Latency: write and read both take effect at the enabling clock edge; read data is registered.
// Backpressure: none; the caller decides when to enable a read or write.
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DMEM_SIZE  = 64,
  parameter int IDX_W      = $clog2(DMEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately left unreset so the storage maps onto plain RAM.
  logic [DATA_WIDTH-1:0] mem_q [DMEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Word write at the enabling edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  // Read data is the addressed word on a read, otherwise the quiet value so the
  // response bus reads zero for stores and between responses.
  always_comb begin
    rdata_d = DATA_WIDTH'(STORE_RDATA);
    if (re) begin
      rdata_d = mem_q[idx];
    end
  end

  // Registered read port, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Thread-tagged multi-cycle data-memory responder with thread-group swap requests.
// Latency: LATENCY cycles accept-to-response; swap pulse the cycle after accept/reject.
// Backpressure: requests arriving while busy are rejected (swap pulse, core replays).
// Option: DMEM_RESP_POSTED_WRITE_EN makes idle/RESP stores complete at the accept edge
// with no swap pulse and no response.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DMEM_SIZE     = 64,
  parameter int NUM_THREADS   = 4,
  parameter int LATENCY       = 4,
  localparam int TID_W        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [TID_W-1:0]         req_tid,
  output logic                     swap_tgrp,
  output logic [TID_W-1:0]         stall_tid,
  output logic                     resp_valid,
  output logic [TID_W-1:0]         resp_tid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     busy
);

  localparam int IDX_W = $clog2(DMEM_SIZE);
  localparam int CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TID_W-1:0]      tid_q, tid_d;
  logic                  swap_q, swap_d;
  logic [TID_W-1:0]      stall_tid_q, stall_tid_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [TID_W-1:0]      resp_tid_q, resp_tid_d;
  logic                  busy_q, busy_d;

  logic                  arr_we;
  logic                  arr_re;
  logic [IDX_W-1:0]      arr_idx;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  logic [IDX_W-1:0]      req_idx;
  logic                  posted_wr;
  logic                  addr_unused;

  // Byte offset is dropped and upper bits beyond the array wrap around.
  assign req_idx     = req_addr[WORD_OFFSET +: IDX_W];
  assign addr_unused = ^req_addr;

`ifdef DMEM_RESP_POSTED_WRITE_EN
  assign posted_wr = req_valid & req_we;
`else
  assign posted_wr = 1'b0;
`endif

  // Next-state, request capture, array control and registered-output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    tid_d        = tid_q;
    swap_d       = 1'b0;
    stall_tid_d  = stall_tid_q;
    resp_valid_d = 1'b0;
    resp_tid_d   = resp_tid_q;
    arr_we       = 1'b0;
    arr_re       = 1'b0;
    arr_idx      = idx_q;
    arr_wdata    = wdata_q;

    unique case (state_q)
      IDLE, RESP: begin
        // RESP lasts one cycle; a request here is accepted just like in IDLE.
        state_d = IDLE;
        if (req_valid) begin
          if (posted_wr) begin
            arr_we    = 1'b1;
            arr_idx   = req_idx;
            arr_wdata = req_wdata;
          end else begin
            we_d        = req_we;
            idx_d       = req_idx;
            wdata_d     = req_wdata;
            tid_d       = req_tid;
            cnt_d       = CNT_LOAD;
            state_d     = BUSY;
            swap_d      = 1'b1;
            stall_tid_d = req_tid;
          end
        end
      end

      BUSY: begin
        if (cnt_q == '0) begin
          // Edge entering RESP: commit the store or register the load data.
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_tid_d   = tid_q;
          arr_we       = we_q;
          arr_re       = ~we_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        // A request while busy is dropped; the swap pulse tells the core to replay it.
        if (req_valid) begin
          swap_d      = 1'b1;
          stall_tid_d = req_tid;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, captured request and output registers; reset drops any pending access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      tid_q        <= '0;
      swap_q       <= 1'b0;
      stall_tid_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_tid_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      tid_q        <= tid_d;
      swap_q       <= swap_d;
      stall_tid_q  <= stall_tid_d;
      resp_valid_q <= resp_valid_d;
      resp_tid_q   <= resp_tid_d;
      busy_q       <= busy_d;
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DMEM_SIZE  (DMEM_SIZE),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign swap_tgrp  = swap_q;
  assign stall_tid  = stall_tid_q;
  assign resp_valid = resp_valid_q;
  assign resp_tid   = resp_tid_q;
  assign resp_rdata = arr_rdata;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, corner sequences and random traffic
// checked against a cycle-count reference model.
// Build with DMEM_RESP_POSTED_WRITE_EN defined to cover the posted-store option.
module tb_dmem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_tid = '0;
  logic        swap_tgrp;
  logic [1:0]  stall_tid;
  logic        resp_valid;
  logic [1:0]  resp_tid;
  logic [31:0] resp_rdata;
  logic        busy;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .DMEM_SIZE     (DEPTH),
    .NUM_THREADS   (4),
    .LATENCY       (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tid    (req_tid),
    .swap_tgrp  (swap_tgrp),
    .stall_tid  (stall_tid),
    .resp_valid (resp_valid),
    .resp_tid   (resp_tid),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: edge counter, edge at which the outstanding access completes,
  // the outstanding access itself and a plain word array.
  int          edge_n    = 0;
  int          resp_edge = -1;
  bit          p_we;
  int          p_idx;
  logic [31:0] p_wdata;
  logic [1:0]  p_tid;
  logic [31:0] mem_m [DEPTH];

  bit          exp_swap   = 1'b0;
  logic [1:0]  exp_stall  = '0;
  bit          exp_rv     = 1'b0;
  logic [1:0]  exp_rtid   = '0;
  logic [31:0] exp_rdata  = '0;
  bit          exp_busy   = 1'b0;

  typedef struct {
    bit          v;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  tid;
    bit          swap;
    logic [1:0]  stall;
    bit          rv;
    logic [1:0]  rtid;
    logic [31:0] rdata;
    bit          busy;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input bit v, input bit we, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] t,
                              input bit s, input logic [1:0] st, input bit rv,
                              input logic [1:0] rt, input logic [31:0] rd, input bit b);
    vec_t r;
    r.v = v; r.we = we; r.addr = a; r.data = d; r.tid = t;
    r.swap = s; r.stall = st; r.rv = rv; r.rtid = rt; r.rdata = rd; r.busy = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".swap"},  {31'b0, swap_tgrp},  {31'b0, exp_swap});
    chk({tag, ".stall"}, {30'b0, stall_tid},  {30'b0, exp_stall});
    chk({tag, ".rv"},    {31'b0, resp_valid}, {31'b0, exp_rv});
    chk({tag, ".rtid"},  {30'b0, resp_tid},   {30'b0, exp_rtid});
    chk({tag, ".rdata"}, resp_rdata,          exp_rdata);
    chk({tag, ".busy"},  {31'b0, busy},       {31'b0, exp_busy});
  endtask

  // Advance the model by one clock edge given the request presented before it.
  task automatic model_edge(input bit v, input bit we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] tid);
    bit free;
    int idx;
    edge_n++;
    free      = (resp_edge < edge_n);
    exp_swap  = 1'b0;
    exp_rv    = 1'b0;
    exp_rdata = '0;
    if (resp_edge == edge_n) begin
      exp_rv   = 1'b1;
      exp_rtid = p_tid;
      if (p_we) mem_m[p_idx] = p_wdata;
      else      exp_rdata = mem_m[p_idx];
    end
    idx = int'((addr >> 2) % 32'(DEPTH));
    if (v) begin
      if (!free) begin
        exp_swap  = 1'b1;
        exp_stall = tid;
`ifdef DMEM_RESP_POSTED_WRITE_EN
      end else if (we) begin
        mem_m[idx] = data;
`endif
      end else begin
        exp_swap  = 1'b1;
        exp_stall = tid;
        resp_edge = edge_n + LAT;
        p_we      = we;
        p_idx     = idx;
        p_wdata   = data;
        p_tid     = tid;
      end
    end
    exp_busy = (resp_edge >= edge_n);
  endtask

  task automatic step(input bit v, input bit we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [1:0] tid);
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_tid   = tid;
    @(posedge clk);
    model_edge(v, we, addr, data, tid);
    #1;
    check_outputs("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst       = 1'b0;
    resp_edge = -1;
    exp_swap  = 1'b0; exp_stall = '0; exp_rv = 1'b0;
    exp_rtid  = '0;   exp_rdata = '0; exp_busy = 1'b0;
    #1;
    check_outputs("reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_outputs("reset");
    end
    rst = 1'b1;
  endtask

  bit seen_rv;

  initial begin
    #2;
    do_reset();

    // Fill every word through the interface so the model knows all contents.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 32'(i * 4), (i == 2) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i), 2'd0);
      idle(LAT);
    end

    // Directed table right after reset: load, reject, alias, accept in RESP.
    do_reset();
    tbl[0]  = mk(1, 0, 32'h8,   0, 2,  1, 2, 0, 0, 32'h0,        1);
    tbl[1]  = mk(0, 0, 32'h0,   0, 0,  0, 2, 0, 0, 32'h0,        1);
    tbl[2]  = mk(1, 0, 32'h104, 0, 3,  1, 3, 0, 0, 32'h0,        1);
    tbl[3]  = mk(0, 0, 32'h0,   0, 0,  0, 3, 0, 0, 32'h0,        1);
    tbl[4]  = mk(0, 0, 32'h0,   0, 0,  0, 3, 1, 2, 32'hDEADBEEF, 1);
    tbl[5]  = mk(1, 0, 32'h105, 0, 1,  1, 1, 0, 2, 32'h0,        1);
    tbl[6]  = mk(0, 0, 32'h0,   0, 0,  0, 1, 0, 2, 32'h0,        1);
    tbl[7]  = mk(0, 0, 32'h0,   0, 0,  0, 1, 0, 2, 32'h0,        1);
    tbl[8]  = mk(0, 0, 32'h0,   0, 0,  0, 1, 0, 2, 32'h0,        1);
    tbl[9]  = mk(0, 0, 32'h0,   0, 0,  0, 1, 1, 1, 32'h1000_0001, 1);
    tbl[10] = mk(0, 0, 32'h0,   0, 0,  0, 1, 0, 1, 32'h0,        0);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].tid);
      chk("tbl.swap",  {31'b0, swap_tgrp},  {31'b0, tbl[i].swap});
      chk("tbl.stall", {30'b0, stall_tid},  {30'b0, tbl[i].stall});
      chk("tbl.rv",    {31'b0, resp_valid}, {31'b0, tbl[i].rv});
      chk("tbl.rtid",  {30'b0, resp_tid},   {30'b0, tbl[i].rtid});
      chk("tbl.rdata", resp_rdata,          tbl[i].rdata);
      chk("tbl.busy",  {31'b0, busy},       {31'b0, tbl[i].busy});
    end

`ifndef DMEM_RESP_POSTED_WRITE_EN
    // Store then a load of the same word issued in the store's RESP cycle.
    step(1'b1, 1'b1, 32'h10, 32'h12345678, 2'd1);
    idle(3);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    chk("st.rv",    {31'b0, resp_valid}, 32'd1);
    chk("st.rdata", resp_rdata, 32'h0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 2'd2);
    chk("ld_in_resp.swap", {31'b0, swap_tgrp}, 32'd1);
    idle(3);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    chk("ld_after_st.rdata", resp_rdata, 32'h12345678);
`else
    // Posted store in IDLE: no pulse, never busy, visible to the next load.
    step(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 2'd1);
    chk("posted.swap", {31'b0, swap_tgrp}, 32'd0);
    chk("posted.busy", {31'b0, busy}, 32'd0);
    step(1'b1, 1'b0, 32'h30, 32'h0, 2'd1);
    idle(LAT);
    chk("posted.rdata", resp_rdata, 32'h5A5A5A5A);
`endif

    // Store from tid 3 while busy is rejected and never lands in the array.
    step(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
    step(1'b1, 1'b1, 32'h44, 32'hFFFF0000, 2'd3);
    chk("rej.swap",  {31'b0, swap_tgrp}, 32'd1);
    chk("rej.stall", {30'b0, stall_tid}, 32'd3);
    idle(3);
    chk("rej.orig_rdata", resp_rdata, 32'h1000_0010);
    step(1'b1, 1'b0, 32'h44, 32'h0, 2'd1);
    idle(LAT);
    chk("rej.not_written", resp_rdata, 32'h1000_0011);

    // Reset two cycles after accepting an access: nothing completes.
`ifndef DMEM_RESP_POSTED_WRITE_EN
    step(1'b1, 1'b1, 32'h20, 32'hBAD0BAD0, 2'd2);
`else
    step(1'b1, 1'b0, 32'h20, 32'h0, 2'd2);
`endif
    idle(2);
    do_reset();
    seen_rv = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      if (resp_valid) seen_rv = 1'b1;
    end
    chk("rst_mid.no_resp", {31'b0, seen_rv}, 32'd0);
    step(1'b1, 1'b0, 32'h20, 32'h0, 2'd0);
    idle(LAT);
    chk("rst_mid.not_committed", resp_rdata, 32'h1000_0008);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           2'($urandom_range(0, 3)));
    end
    idle(LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
